// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage.
//   ld_size_e  : load access size (byte / half / word)
//   ld_entry_t : one outstanding-load record {rd, size, unsigned, offset}
//   ADDR_WIDTH / WORD_WIDTH : register address and data widths
package riscv_defines;

    localparam int ADDR_WIDTH = 5;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        ld_size_e              size;
        logic                  uns;
        logic [1:0]            offset;
    } ld_entry_t;

endpackage

// File: rtl/wb_stage_ld_align.sv
// ld_align: combinational extract-and-extend of a raw LSU read word.
//   rdata      in  raw LSU word
//   size       in  access size
//   uns        in  1 = zero-extend, 0 = sign-extend
//   offset     in  address bits [1:0]
//   data       out aligned, extended result
//   misaligned out half at odd offset, or word at nonzero offset
// Misaligned accesses still produce data using the truncated offset.
module ld_align
    import riscv_defines::*;
(
    input  logic [WORD_WIDTH-1:0] rdata,
    input  ld_size_e              size,
    input  logic                  uns,
    input  logic [1:0]            offset,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{offset, 3'b000} +: 8];
        half_v     = rdata[{offset[1], 4'b0000} +: 16];
        data       = rdata;
        misaligned = 1'b0;
        case (size)
            LD_BYTE: begin
                data = {{24{~uns & byte_v[7]}}, byte_v};
            end
            LD_HALF: begin
                data       = {{16{~uns & half_v[15]}}, half_v};
                misaligned = offset[0];
            end
            default: begin
                data       = rdata;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Merges ALU results and LSU load data into the
// single register-bank write port, tracks outstanding loads in an in-order
// queue and raises a source-register hazard for decode.
//   clk, rst                         clock, async active-high reset
//   ex_valid_i/ex_rd_i/ex_wd_i       ALU result; ex_ready_o = accepted
//   ld_issue_i/ld_rd_i/ld_size_i/
//   ld_unsigned_i/ld_offset_i        load issue record; ld_full_o = queue full
//   lsu_rvalid_i/lsu_rdata_i         in-order load response (never stalled)
//   rs1_i/rs2_i, hazard_o            decode sources and stall request
//   addr_wd_o/wd_o/wen_o             register-bank write port (registered)
//   err_o                            sticky protocol / misalignment error
// Optional build macro WB_FWD_EN adds fwd_valid_o/fwd_rd_o/fwd_data_o and
// removes the in-flight-write term from hazard_o.
module wb_stage
    import riscv_defines::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_WIDTH = 32,
    parameter int LD_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic [ADDR_WIDTH-1:0] ex_rd_i,
    input  logic [WORD_WIDTH-1:0] ex_wd_i,
    output logic                  ex_ready_o,
    input  logic                  ld_issue_i,
    input  logic [ADDR_WIDTH-1:0] ld_rd_i,
    input  logic [1:0]            ld_size_i,
    input  logic                  ld_unsigned_i,
    input  logic [1:0]            ld_offset_i,
    output logic                  ld_full_o,
    input  logic                  lsu_rvalid_i,
    input  logic [WORD_WIDTH-1:0] lsu_rdata_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    output logic                  hazard_o,
    output logic [ADDR_WIDTH-1:0] addr_wd_o,
    output logic [WORD_WIDTH-1:0] wd_o,
    output logic                  wen_o,
    output logic                  err_o
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid_o,
    output logic [ADDR_WIDTH-1:0] fwd_rd_o,
    output logic [WORD_WIDTH-1:0] fwd_data_o
`endif
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = $clog2(LD_DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(LD_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

    ld_entry_t             q [LD_DEPTH];
    logic [LD_DEPTH-1:0]   q_valid;
    logic [PW-1:0]         rptr, wptr;
    logic [CW-1:0]         count, count_nxt;
    logic                  full_q, err_q;
    logic                  pop, push;
    ld_entry_t             head;
    logic [WORD_WIDTH-1:0] align_data;
    logic                  misaligned;
    logic                  q_hit;

    assign head = q[rptr];
    // A response with nothing outstanding is dropped, not popped.
    assign pop  = lsu_rvalid_i && (count != '0);
    // When full, an issue is only taken if the same cycle frees a slot.
    assign push = ld_issue_i && (!full_q || pop);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    ld_align u_ld_align (
        .rdata      (lsu_rdata_i),
        .size       (head.size),
        .uns        (head.uns),
        .offset     (head.offset),
        .data       (align_data),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            q_valid <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            if (pop) begin
                q_valid[rptr] <= 1'b0;
                rptr          <= (rptr == PTR_MAX) ? '0 : rptr + PW'(1);
            end
            // Placed after the pop so a full-queue push/pop on the same slot
            // leaves that slot valid.
            if (push) begin
                q[wptr]       <= '{rd: ld_rd_i, size: ld_size_e'(ld_size_i),
                                   uns: ld_unsigned_i, offset: ld_offset_i};
                q_valid[wptr] <= 1'b1;
                wptr          <= (wptr == PTR_MAX) ? '0 : wptr + PW'(1);
            end
            count  <= count_nxt;
            full_q <= (count_nxt == DEPTH_C);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((lsu_rvalid_i && count == '0) ||
                     (ld_issue_i && full_q && !pop) ||
                     (pop && misaligned)) begin
            err_q <= 1'b1;
        end
    end

    assign ex_ready_o = !lsu_rvalid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_wd_o <= '0;
            wd_o      <= '0;
            wen_o     <= 1'b0;
        end else begin
            wen_o <= 1'b0;
            if (pop) begin
                addr_wd_o <= head.rd;
                wd_o      <= align_data;
                wen_o     <= (head.rd != '0);
            end else if (ex_valid_i && ex_ready_o) begin
                addr_wd_o <= ex_rd_i;
                wd_o      <= ex_wd_i;
                wen_o     <= (ex_rd_i != '0);
            end
        end
    end

    // The entry being popped this cycle still counts: its data is not in
    // the bank until two edges later.
    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (q_valid[i] && ((rs1_i != '0 && q[i].rd == rs1_i) ||
                               (rs2_i != '0 && q[i].rd == rs2_i))) begin
                q_hit = 1'b1;
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid_o = wen_o;
    assign fwd_rd_o    = addr_wd_o;
    assign fwd_data_o  = wd_o;
    assign hazard_o    = q_hit;
`else
    // Without a bypass the bank read of the in-flight register is stale.
    assign hazard_o = q_hit ||
                      (wen_o && ((rs1_i != '0 && rs1_i == addr_wd_o) ||
                                 (rs2_i != '0 && rs2_i == addr_wd_o)));
`endif

    assign ld_full_o = full_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_wd_i;
    logic        ex_ready_o;
    logic        ld_issue_i;
    logic [4:0]  ld_rd_i;
    logic [1:0]  ld_size_i;
    logic        ld_unsigned_i;
    logic [1:0]  ld_offset_i;
    logic        ld_full_o;
    logic        lsu_rvalid_i;
    logic [31:0] lsu_rdata_i;
    logic [4:0]  rs1_i, rs2_i;
    logic        hazard_o;
    logic [4:0]  addr_wd_o;
    logic [31:0] wd_o;
    logic        wen_o;
    logic        err_o;
`ifdef WB_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
`endif

    always #5 clk = ~clk;

    wb_stage #(.ADDR_WIDTH(5), .WORD_WIDTH(32), .LD_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_i    (ex_valid_i),
        .ex_rd_i       (ex_rd_i),
        .ex_wd_i       (ex_wd_i),
        .ex_ready_o    (ex_ready_o),
        .ld_issue_i    (ld_issue_i),
        .ld_rd_i       (ld_rd_i),
        .ld_size_i     (ld_size_i),
        .ld_unsigned_i (ld_unsigned_i),
        .ld_offset_i   (ld_offset_i),
        .ld_full_o     (ld_full_o),
        .lsu_rvalid_i  (lsu_rvalid_i),
        .lsu_rdata_i   (lsu_rdata_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .hazard_o      (hazard_o),
        .addr_wd_o     (addr_wd_o),
        .wd_o          (wd_o),
        .wen_o         (wen_o),
        .err_o         (err_o)
`ifdef WB_FWD_EN
        ,
        .fwd_valid_o   (fwd_valid_o),
        .fwd_rd_o      (fwd_rd_o),
        .fwd_data_o    (fwd_data_o)
`endif
    );

    typedef struct {
        int rd;
        int size;
        bit uns;
        int off;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_wd;
    logic        m_err;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] extract(input logic [31:0] w, input int size,
                                            input bit uns, input int off);
        logic [31:0] v;
        if (size == 0) begin
            v = (w >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit misal(input int size, input int off);
        return (size == 1 && (off % 2) == 1) || (size == 2 && off != 0);
    endfunction

    task automatic idle();
        ex_valid_i    = 1'b0;
        ex_rd_i       = '0;
        ex_wd_i       = '0;
        ld_issue_i    = 1'b0;
        ld_rd_i       = '0;
        ld_size_i     = 2'd0;
        ld_unsigned_i = 1'b0;
        ld_offset_i   = 2'd0;
        lsu_rvalid_i  = 1'b0;
        lsu_rdata_i   = '0;
        rs1_i         = '0;
        rs2_i         = '0;
    endtask

    // One clock: check combinational outputs against the model, advance the
    // model, then check the registered outputs just after the edge.
    task automatic tick();
        bit          hz;
        bit          nwen;
        m_ent_t      e;
        #1;
        hz = 0;
        foreach (mq[i]) begin
            if (mq[i].rd != 0 && (mq[i].rd == int'(rs1_i) || mq[i].rd == int'(rs2_i))) hz = 1;
        end
`ifndef WB_FWD_EN
        if (m_wen && m_addr != 0 && (m_addr == rs1_i || m_addr == rs2_i)) hz = 1;
`endif
        chk("ex_ready", 32'(ex_ready_o), 32'(!lsu_rvalid_i));
        chk("hazard", 32'(hazard_o), 32'(hz));

        nwen = 0;
        if (lsu_rvalid_i) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                e      = mq.pop_front();
                m_addr = 5'(e.rd);
                m_wd   = extract(lsu_rdata_i, e.size, e.uns, e.off);
                nwen   = (e.rd != 0);
                if (misal(e.size, e.off)) m_err = 1'b1;
            end
        end else if (ex_valid_i) begin
            m_addr = ex_rd_i;
            m_wd   = ex_wd_i;
            nwen   = (ex_rd_i != 0);
        end
        m_wen = nwen;
        if (ld_issue_i) begin
            if (mq.size() < DEPTH)
                mq.push_back('{rd: int'(ld_rd_i), size: int'(ld_size_i),
                               uns: ld_unsigned_i, off: int'(ld_offset_i)});
            else
                m_err = 1'b1;
        end

        @(posedge clk);
        #1;
        chk("wen", 32'(wen_o), 32'(m_wen));
        chk("addr_wd", 32'(addr_wd_o), 32'(m_addr));
        chk("wd", wd_o, m_wd);
        chk("err", 32'(err_o), 32'(m_err));
        chk("ld_full", 32'(ld_full_o), 32'(mq.size() == DEPTH));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq.delete();
        m_wen  = 1'b0;
        m_addr = '0;
        m_wd   = '0;
        m_err  = 1'b0;
        #2;
        chk("rst_wen", 32'(wen_o), 32'd0);
        chk("rst_addr", 32'(addr_wd_o), 32'd0);
        chk("rst_wd", wd_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_full", 32'(ld_full_o), 32'd0);
        chk("rst_hazard", 32'(hazard_o), 32'd0);
        rst = 1'b0;
    endtask

    task automatic issue(input int rd, input int size, input bit uns, input int off);
        ld_issue_i    = 1'b1;
        ld_rd_i       = 5'(rd);
        ld_size_i     = 2'(size);
        ld_unsigned_i = uns;
        ld_offset_i   = 2'(off);
    endtask

    initial begin
        idle();
        do_reset();

        // ALU only
        idle(); ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_wd_i = 32'hDEAD_BEEF;
        tick();
        chk("alu_wen", 32'(wen_o), 32'd1);
        chk("alu_wd", wd_o, 32'hDEAD_BEEF);

        // Signed then unsigned byte load, offset 2
        idle(); issue(5, 0, 0, 2); tick();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0080_0000; rs2_i = 5'd5; tick();
        chk("sbyte_wd", wd_o, 32'hFFFF_FF80);
        idle(); issue(5, 0, 1, 2); tick();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0080_0000; tick();
        chk("ubyte_wd", wd_o, 32'h0000_0080);

        // Conflict: load wins, ALU re-presented next cycle
        idle(); issue(9, 2, 0, 0); tick();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h1234_5678;
        ex_valid_i = 1'b1; ex_rd_i = 5'd10; ex_wd_i = 32'hCAFE_0001; tick();
        chk("conf_addr", 32'(addr_wd_o), 32'd9);
        idle(); ex_valid_i = 1'b1; ex_rd_i = 5'd10; ex_wd_i = 32'hCAFE_0001; tick();
        chk("conf_alu_addr", 32'(addr_wd_o), 32'd10);

        // Scoreboard hazard on rd=7, then rd=0 never hazards
        idle(); issue(7, 2, 0, 0); tick();
        idle(); rs2_i = 5'd7; tick();
        chk("sb_hazard", 32'(hazard_o), 32'd1);
        idle(); rs2_i = 5'd7; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hA5A5_0007; tick();
        idle(); rs2_i = 5'd7; tick();
        idle(); issue(0, 2, 0, 0); tick();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0000_1111; tick();
        chk("x0_wen", 32'(wen_o), 32'd0);

        // Fill, then issue+pop while full
        idle(); issue(11, 1, 0, 2); tick();
        idle(); issue(12, 1, 1, 0); tick();
        chk("full_set", 32'(ld_full_o), 32'd1);
        idle(); issue(13, 0, 1, 3); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h8001_7FFE; tick();
        chk("full_hold", 32'(ld_full_o), 32'd1);
        chk("full_err", 32'(err_o), 32'd0);
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0000_9ABC; tick();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h4400_0000; tick();

        // In-flight write hazard for exactly one cycle
        idle(); ex_valid_i = 1'b1; ex_rd_i = 5'd12; ex_wd_i = 32'h0000_0C0C; tick();
        idle(); rs1_i = 5'd12; tick();
        idle(); rs1_i = 5'd12; tick();

        // Response on empty queue
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hFFFF_FFFF; tick();
        chk("empty_err", 32'(err_o), 32'd1);
        chk("empty_wen", 32'(wen_o), 32'd0);

        // Reset with two pending loads
        do_reset();
        idle(); issue(20, 2, 0, 0); tick();
        idle(); issue(21, 2, 0, 0); tick();
        idle(); rs1_i = 5'd20; rs2_i = 5'd21;
        do_reset();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h1; tick();

        // Misaligned half load still writes
        do_reset();
        idle(); issue(14, 1, 0, 3); tick();
        idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h8765_4321; tick();

        // Randomized traffic against the model
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int c = 0; c < 100; c++) begin
                int sz;
                int off;
                idle();
                ex_valid_i = 1'($urandom_range(0, 1));
                ex_rd_i    = 5'($urandom_range(0, 31));
                ex_wd_i    = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    sz  = $urandom_range(0, 2);
                    off = $urandom_range(0, 3);
                    if ($urandom_range(0, 9) != 0) begin
                        if (sz == 1) off = off & 2;
                        if (sz == 2) off = 0;
                    end
                    issue($urandom_range(0, 31), sz, 1'($urandom_range(0, 1)), off);
                end
                if (mq.size() > 0) lsu_rvalid_i = 1'($urandom_range(0, 1));
                else lsu_rvalid_i = ($urandom_range(0, 19) == 0);
                lsu_rdata_i = $urandom;
                if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                    rs1_i = 5'(mq[0].rd);
                else
                    rs1_i = 5'($urandom_range(0, 31));
                rs2_i = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RI5CY frontend. It merges ALU results and load-store-unit (LSU) read data into the single register-bank write port, and drives `addr_wd_o` / `wd_o` / `wen_o` straight into the bank. It tracks outstanding loads in an in-order queue, aligns and extends returning load data, and raises a register hazard for the decode stage.

## Interface

Parameters:
- `ADDR_WIDTH`, 5: register address width.
- `WORD_WIDTH`, 32: data width.
- `LD_DEPTH`, 2: maximum outstanding loads; power of two, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid_i`  in  1  ALU result valid.
- `ex_rd_i`  in  ADDR_WIDTH  ALU destination register.
- `ex_wd_i`  in  WORD_WIDTH  ALU result.
- `ex_ready_o`  out  1  ALU result accepted this cycle.
- `ld_issue_i`  in  1  load issued to the LSU this cycle.
- `ld_rd_i`  in  ADDR_WIDTH  load destination register.
- `ld_size_i`  in  2  `ld_size_e`: byte, half or word.
- `ld_unsigned_i`  in  1  zero-extend when set, sign-extend when clear.
- `ld_offset_i`  in  2  address bits [1:0].
- `ld_full_o`  out  1  load queue holds `LD_DEPTH` entries.
- `lsu_rvalid_i`  in  1  LSU read data valid; cannot be stalled.
- `lsu_rdata_i`  in  WORD_WIDTH  raw LSU word.
- `rs1_i`, `rs2_i`  in  ADDR_WIDTH  source registers of the instruction in decode.
- `hazard_o`  out  1  decode must stall.
- `addr_wd_o`  out  ADDR_WIDTH  register-bank write address.
- `wd_o`  out  WORD_WIDTH  register-bank write data.
- `wen_o`  out  1  register-bank write enable.
- `err_o`  out  1  sticky protocol / misalignment error.

## Operation

- Load queue: FIFO of {rd, size, unsigned, offset}, depth `LD_DEPTH`, with read/write pointers and a count.
  - A load is pushed on `ld_issue_i`.
  - An entry is popped on `lsu_rvalid_i`. Responses arrive in order.
- Arbitration: an LSU response always wins the write port.
  - `ex_ready_o = !lsu_rvalid_i`.
  - An ALU result is accepted only when `ex_valid_i && ex_ready_o`.
- Write register: the accepted source is latched into `addr_wd_o` / `wd_o` / `wen_o`.
  - `wen_o` stays 0 when the destination is x0; data is still latched.
- Load alignment (sub-module `ld_align`):
  - Byte: selects `rdata[8*offset +: 8]`.
  - Half: selects `rdata[16*offset[1] +: 16]`.
  - Word: takes all 32 bits.
  - Extension is zero or sign per `ld_unsigned_i`.
  - A half load with `offset[0]=1`, or a word load with `offset!=0`, sets `err_o`. The write still occurs, using the truncated offset.
- Hazard: `hazard_o` = a nonzero rs1 or rs2 equals the rd of any valid queue entry.
  - The matching entry may be the one being popped this cycle.
- Error conditions (each sets `err_o`, which stays set until reset):
  - `lsu_rvalid_i` with the queue empty: the response is dropped and nothing is written.
  - `ld_issue_i` while `ld_full_o` with no simultaneous pop: the issue is dropped.

## Timing

- Reset values: `wen_o`=0, `addr_wd_o`=0, `wd_o`=0, `err_o`=0, `ld_full_o`=0, queue empty. `ex_ready_o` and `hazard_o` are combinational.
- Latency: an accepted ALU result or LSU response appears on `wen_o` exactly one cycle later. It lands in the bank at the following edge.
- Issue timing:
  - An issue at edge N is visible to `hazard_o` and `ld_full_o` from cycle N+1.
  - A response in the same cycle as its own issue is an error, because the queue is empty at that point.
- Simultaneous issue and pop:
  - Count is unchanged.
  - Allowed when full: the pop frees the slot the push uses.
- Pointers wrap modulo `LD_DEPTH`.
- `ld_full_o` is registered, derived from the count.
- Reset mid-operation flushes the queue. Responses that arrive after reset count as errors.

## Configuration

- `WB_FWD_EN` defined:
  - Adds outputs `fwd_valid_o`, `fwd_rd_o`, `fwd_data_o`, equal to `wen_o`, `addr_wd_o`, `wd_o`.
  - Decode bypasses the in-flight write, so a write in flight does not raise `hazard_o`.
- `WB_FWD_EN` undefined:
  - The forwarding ports are absent.
  - `hazard_o` additionally asserts when a nonzero rs1 or rs2 equals `addr_wd_o` while `wen_o`=1. The bank read of that register is still stale in that cycle.

## Structure

- Package `riscv_defines` holds:
  - `ld_size_e` (`LD_BYTE`=0, `LD_HALF`=1, `LD_WORD`=2);
  - the `ld_entry_t` struct;
  - the `ADDR_WIDTH` / `WORD_WIDTH` constants.
- Sub-module `ld_align`: combinational extract and extend, with a misalignment flag output.
- The queue and the write register stay in `wb_stage`.

## Test plan

- ALU only: `ex_valid_i`=1, rd=3, wd=0xDEADBEEF → `ex_ready_o`=1; next cycle `wen_o`=1, `addr_wd_o`=3, `wd_o`=0xDEADBEEF.
- Signed byte load: rd=5, byte, offset=2, signed; response 0x0080_0000 → next cycle `wd_o`=0xFFFFFF80. The same case unsigned → 0x00000080.
- Conflict: `lsu_rvalid_i` and `ex_valid_i` in the same cycle → `ex_ready_o`=0 and the load is written. The ALU result is written the cycle after it is re-presented.
- Scoreboard: issue a load to rd=7, then `rs2_i`=7 → `hazard_o`=1 until the response pops. With `rs1_i`=0 and rd=0 → `hazard_o`=0.
- Boundaries:
  - Fill the queue to 2 → `ld_full_o`=1.
  - Issue plus pop while full → count stays 2, `err_o`=0.
  - Response on an empty queue → `err_o`=1, `wen_o`=0.
- Reset with 2 pending loads → queue empty, `hazard_o`=0, `wen_o`=0.
- Write to x0 → `wen_o` stays 0.
- Without `WB_FWD_EN`: rs1 equals the in-flight `addr_wd_o` → `hazard_o`=1 for that single cycle.
